// File: rtl/mux2_pkg.sv
// Shared types and constants for the mux2 arbiter slice: slot state encoding,
// mux select values and the reset value of the round-robin pointer.
package mux2_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } mux2_arb_state_t;

    localparam logic SEL_I0   = 1'b0;
    localparam logic SEL_I1   = 1'b1;
    // Pointer starts at I1 so the first contention after reset goes to I0.
    localparam logic RST_LAST = 1'b1;

endpackage

// File: rtl/mux2_1.sv
// mux2_1: single-bit 2:1 multiplexer, y = s ? b : a.
module mux2_1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: two valid/ready sources share a W-bit mux2_1 datapath into one registered output slot.
// Define MUX2_ARBITER_RR_EN for round-robin contention; otherwise I0 has fixed priority.
module mux2_arbiter
    import mux2_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i0_valid,
    input  logic [W-1:0] i0_data,
    output logic         i0_ready,
    input  logic         i1_valid,
    input  logic [W-1:0] i1_data,
    output logic         i1_ready,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    input  logic         y_ready,
    output logic         s
);

    mux2_arb_state_t state;
    logic            load;
    logic            winner;
    logic            take;
    logic [W-1:0]    mux_y;
`ifdef MUX2_ARBITER_RR_EN
    logic            last;
`endif

    always_comb begin
        winner = SEL_I0;
        if (i0_valid && i1_valid) begin
`ifdef MUX2_ARBITER_RR_EN
            winner = ~last;
`else
            winner = SEL_I0;
`endif
        end else if (i1_valid) begin
            winner = SEL_I1;
        end
    end

    // Readies are held low while reset is asserted so nothing is accepted in that cycle.
    assign load     = !rst && ((state == EMPTY) || y_ready);
    assign i0_ready = load && i0_valid && (winner == SEL_I0);
    assign i1_ready = load && i1_valid && (winner == SEL_I1);
    assign take     = i0_ready || i1_ready;

    for (genvar i = 0; i < W; i++) begin : g_mux
        mux2_1 u_mux (
            .a (i0_data[i]),
            .b (i1_data[i]),
            .s (winner),
            .y (mux_y[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            y_valid <= 1'b0;
            y_data  <= '0;
            s       <= SEL_I0;
`ifdef MUX2_ARBITER_RR_EN
            last    <= RST_LAST;
`endif
        end else if (take) begin
            state   <= (winner == SEL_I1) ? HOLD1 : HOLD0;
            y_valid <= 1'b1;
            y_data  <= mux_y;
            s       <= winner;
`ifdef MUX2_ARBITER_RR_EN
            last    <= winner;
`endif
        end else if (y_ready) begin
            state   <= EMPTY;
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed testbench for mux2_arbiter; expectations follow MUX2_ARBITER_RR_EN when it is defined.
module tb_mux2_arbiter;

    logic       clk;
    logic       rst;
    logic       i0_valid;
    logic [7:0] i0_data;
    logic       i0_ready;
    logic       i1_valid;
    logic [7:0] i1_data;
    logic       i1_ready;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_ready;
    logic       s;

    int checks = 0;
    int errors = 0;

    mux2_arbiter #(.W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0_valid (i0_valid),
        .i0_data  (i0_data),
        .i0_ready (i0_ready),
        .i1_valid (i1_valid),
        .i1_data  (i1_data),
        .i1_ready (i1_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_ready  (y_ready),
        .s        (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i0_valid = 1'b1; i0_data = 8'hA5; i1_valid = 1'b0; i1_data = 8'h00; y_ready = 1'b0;
        tick();
        checks++; if (y_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_y_valid: got %b expected 0", y_valid); end
        checks++; if (y_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_y_data: got %h expected 00", y_data); end
        checks++; if (i0_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_i0_ready: got %b expected 0", i0_ready); end
        rst = 1'b0;
        #1;
        checks++; if (i0_ready !== 1'b1) begin errors++; $display("[TB] FAIL load_a5_ready: got %b expected 1", i0_ready); end
        tick();
        i0_valid = 1'b0;
        checks++; if (y_valid !== 1'b1 || y_data !== 8'hA5) begin errors++; $display("[TB] FAIL load_a5: got v=%b d=%h expected v=1 d=a5", y_valid, y_data); end
        // Reset mid-cycle with a word in the slot and a source offering data.
        i0_valid = 1'b1; i0_data = 8'h77;
        rst = 1'b1;
        #1;
        checks++; if (y_valid !== 1'b0 || y_data !== 8'h00 || s !== 1'b0) begin errors++; $display("[TB] FAIL async_rst: got v=%b d=%h s=%b expected v=0 d=00 s=0", y_valid, y_data, s); end
        checks++; if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_ready: got %b%b expected 00", i0_ready, i1_ready); end
        tick();
        rst = 1'b0;
        i0_valid = 1'b1; i0_data = 8'h11; i1_valid = 1'b1; i1_data = 8'h22; y_ready = 1'b1;
        #1;
        checks++; if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_grant: got i0=%b i1=%b expected i0=1 i1=0", i0_ready, i1_ready); end
        tick();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h11 || s !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_load: got v=%b d=%h s=%b expected v=1 d=11 s=0", y_valid, y_data, s); end
    endtask

    task automatic test_single();
        i0_valid = 1'b0; i1_valid = 1'b1; i1_data = 8'h3C; y_ready = 1'b1;
        #1;
        checks++; if (i1_ready !== 1'b1 || i0_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready: got i0=%b i1=%b expected i0=0 i1=1", i0_ready, i1_ready); end
        tick();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h3C || s !== 1'b1) begin errors++; $display("[TB] FAIL single_load: got v=%b d=%h s=%b expected v=1 d=3c s=1", y_valid, y_data, s); end
    endtask

    task automatic test_contention();
        logic       exp_sel;
        logic [7:0] exp_data;
        i0_valid = 1'b1; i0_data = 8'h11; i1_valid = 1'b1; i1_data = 8'h22; y_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
`ifdef MUX2_ARBITER_RR_EN
            exp_sel = k[0];
`else
            exp_sel = 1'b0;
`endif
            exp_data = exp_sel ? 8'h22 : 8'h11;
            #1;
            checks++; if (i0_ready !== ~exp_sel || i1_ready !== exp_sel) begin errors++; $display("[TB] FAIL contention_ready[%0d]: got i0=%b i1=%b expected i0=%b i1=%b", k, i0_ready, i1_ready, ~exp_sel, exp_sel); end
            tick();
            checks++; if (y_data !== exp_data || s !== exp_sel || y_valid !== 1'b1) begin errors++; $display("[TB] FAIL contention_out[%0d]: got d=%h s=%b v=%b expected d=%h s=%b v=1", k, y_data, s, y_valid, exp_data, exp_sel); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] held_data;
        logic       held_s;
`ifdef MUX2_ARBITER_RR_EN
        held_data = 8'h22; held_s = 1'b1;
`else
        held_data = 8'h11; held_s = 1'b0;
`endif
        i0_valid = 1'b1; i0_data = 8'h33; i1_valid = 1'b1; i1_data = 8'h44; y_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got i0=%b i1=%b expected 0 0", k, i0_ready, i1_ready); end
            tick();
            checks++; if (y_data !== held_data || s !== held_s || y_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got d=%h s=%b v=%b expected d=%h s=%b v=1", k, y_data, s, y_valid, held_data, held_s); end
        end
        y_ready = 1'b1;
        #1;
        checks++; if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_ready: got i0=%b i1=%b expected i0=1 i1=0", i0_ready, i1_ready); end
        tick();
        checks++; if (y_data !== 8'h33 || s !== 1'b0 || y_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_load: got d=%h s=%b v=%b expected d=33 s=0 v=1", y_data, s, y_valid); end
    endtask

    task automatic test_drain();
        i0_valid = 1'b0; i1_valid = 1'b0; y_ready = 1'b1;
        #1;
        checks++; if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_ready: got i0=%b i1=%b expected 0 0", i0_ready, i1_ready); end
        tick();
        checks++; if (y_valid !== 1'b0 || y_data !== 8'h33 || s !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got v=%b d=%h s=%b expected v=0 d=33 s=0", y_valid, y_data, s); end
        tick();
        checks++; if (y_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_stay_empty: got %b expected 0", y_valid); end
        // An empty slot loads even while the consumer is not ready.
        i1_valid = 1'b1; i1_data = 8'h55; y_ready = 1'b0;
        #1;
        checks++; if (i1_ready !== 1'b1) begin errors++; $display("[TB] FAIL empty_load_ready: got %b expected 1", i1_ready); end
        tick();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h55 || s !== 1'b1) begin errors++; $display("[TB] FAIL empty_load: got v=%b d=%h s=%b expected v=1 d=55 s=1", y_valid, y_data, s); end
        i1_valid = 1'b0;
    endtask

`ifndef MUX2_ARBITER_RR_EN
    task automatic test_priority();
        i0_valid = 1'b1; i0_data = 8'h11; i1_valid = 1'b1; i1_data = 8'h22; y_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (i1_ready !== 1'b0) begin errors++; $display("[TB] FAIL prio_i1_ready[%0d]: got %b expected 0", k, i1_ready); end
            tick();
            checks++; if (y_data !== 8'h11 || s !== 1'b0) begin errors++; $display("[TB] FAIL prio_out[%0d]: got d=%h s=%b expected d=11 s=0", k, y_data, s); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_drain();
`ifndef MUX2_ARBITER_RR_EN
        test_priority();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
